// File: rtl/oled_seq_pkg.sv
// Shared state encoding and SSD1306 init command table
// for the OLED boot sequencer.
package oled_seq_pkg;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        CS_ON,
        INIT_SEND,
        INIT_WAIT,
        READY,
        XFER_SEND,
        XFER_WAIT
    } state_e;

    localparam int INIT_LEN = 25;

    localparam logic [0:INIT_LEN-1][7:0] INIT_BYTES = {
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
        8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
        8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

endpackage

// File: rtl/oled_init_rom.sv
// Combinational lookup of the SSD1306 init command bytes.
// Indices past the end of the table read as zero.
module oled_init_rom
    import oled_seq_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        if (int'(idx) < INIT_LEN) data = INIT_BYTES[idx];
    end

endmodule

// File: rtl/oled_boot_seq.sv
// SSD1306 power-up sequencer: reset pulse, init command burst,
// then CPU pass-through with CS framing and idle CS release.
module oled_boot_seq
    import oled_seq_pkg::*;
#(
    parameter string SIMULATE    = "FALSE",
    parameter int    RST_CYCLES  = 120,
    parameter int    WAIT_CYCLES = 1200,
    parameter int    CS_IDLE     = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_init,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_data,
    input  logic       cpu_dc,
    output logic       cpu_busy,
    output logic       ready,
    output logic       spi_start,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       oled_rst_n,
    output logic       oled_cs_n,
    output logic       oled_dc
);

    localparam bit SIM    = (SIMULATE == "TRUE");
    localparam int RST_N  = SIM ? 4 : RST_CYCLES;
    localparam int WAIT_N = SIM ? 4 : WAIT_CYCLES;
    localparam int IDLE_N = SIM ? 4 : CS_IDLE;
    localparam int MAX_RW = (RST_N > WAIT_N) ? RST_N : WAIT_N;
    localparam int MAX_N  = (MAX_RW > IDLE_N) ? MAX_RW : IDLE_N;
    localparam int CW     = (MAX_N > 2) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_N - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_N - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_N - 1);
    localparam logic [4:0]    IDX_LAST  = 5'(INIT_LEN - 1);

    state_e        state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic [4:0]    idx, idx_d, rom_idx;
    logic [7:0]    rom_byte;
    logic [7:0]    wr_data, wr_data_d;
    logic          wr_dc, wr_dc_d;
    logic          soft_pend, soft_d;
    logic          restart;
    logic          rst_n_d, cs_n_d, dc_d, start_d;
    logic [7:0]    data_d;
    logic          ready_d, busy_d;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // The ROM is addressed by the byte about to be sent.
    assign rom_idx = (state == INIT_WAIT) ? idx + 5'd1 : idx;

    oled_init_rom u_rom (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx;
        wr_data_d = wr_data;
        wr_dc_d   = wr_dc;
        soft_d    = soft_pend;
        restart   = 1'b0;
        rst_n_d   = oled_rst_n;
        cs_n_d    = oled_cs_n;
        dc_d      = oled_dc;
        start_d   = 1'b0;
        data_d    = spi_data;
        ready_d   = ready;
        busy_d    = cpu_busy;

        unique case (state)
            RST_LOW: begin
                if (cnt == RST_LAST) begin
                    rst_n_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RST_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    cs_n_d  = 1'b0;
                    state_d = CS_ON;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CS_ON: begin
                if (ready) begin
                    state_d = XFER_SEND;
                end else begin
                    start_d = 1'b1;
                    dc_d    = 1'b0;
                    data_d  = rom_byte;
                    state_d = INIT_SEND;
                end
            end
            INIT_SEND: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (soft_init) soft_d = 1'b1;
                if (spi_done) begin
                    if (soft_pend || soft_init) begin
                        restart = 1'b1;
                    end else if (idx == IDX_LAST) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = READY;
                    end else begin
                        idx_d   = idx + 5'd1;
                        start_d = 1'b1;
                        dc_d    = 1'b0;
                        data_d  = rom_byte;
                        state_d = INIT_SEND;
                    end
                end
            end
            READY: begin
                if (soft_init) begin
                    restart = 1'b1;
                end else if (cpu_wr && !cpu_busy) begin
                    wr_data_d = cpu_data;
                    wr_dc_d   = cpu_dc;
                    busy_d    = 1'b1;
                    if (oled_cs_n) begin
                        cs_n_d  = 1'b0;
                        state_d = CS_ON;
                    end else begin
                        state_d = XFER_SEND;
                    end
                end else if (!oled_cs_n) begin
                    if (cnt == IDLE_LAST) cs_n_d = 1'b1;
                    else                  cnt_d  = cnt_inc;
                end
            end
            XFER_SEND: begin
                start_d = 1'b1;
                dc_d    = wr_dc;
                data_d  = wr_data;
                state_d = XFER_WAIT;
            end
            XFER_WAIT: begin
                if (soft_init) soft_d = 1'b1;
                if (spi_done) begin
                    if (soft_pend || soft_init) begin
                        restart = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = READY;
                    end
                end
            end
            default: state_d = RST_LOW;
        endcase

        if (restart) begin
            state_d = RST_LOW;
            cnt_d   = '0;
            idx_d   = '0;
            soft_d  = 1'b0;
            rst_n_d = 1'b0;
            cs_n_d  = 1'b1;
            dc_d    = 1'b0;
            start_d = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RST_LOW;
            cnt        <= '0;
            idx        <= '0;
            wr_data    <= 8'h00;
            wr_dc      <= 1'b0;
            soft_pend  <= 1'b0;
            oled_rst_n <= 1'b0;
            oled_cs_n  <= 1'b1;
            oled_dc    <= 1'b0;
            spi_start  <= 1'b0;
            spi_data   <= 8'h00;
            ready      <= 1'b0;
            cpu_busy   <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            wr_data    <= wr_data_d;
            wr_dc      <= wr_dc_d;
            soft_pend  <= soft_d;
            oled_rst_n <= rst_n_d;
            oled_cs_n  <= cs_n_d;
            oled_dc    <= dc_d;
            spi_start  <= start_d;
            spi_data   <= data_d;
            ready      <= ready_d;
            cpu_busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_oled_boot_seq.sv
// Scoreboard bench for oled_boot_seq: SPI master model answers
// each spi_start with spi_done three cycles later.
module tb_oled_boot_seq;

    typedef struct {
        int         cyc;
        logic       cs_n;
        logic       dc;
        logic [7:0] data;
        logic       prev_dc;
    } obs_t;

    typedef struct {
        logic       dc;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_init;
    logic       cpu_wr;
    logic [7:0] cpu_data;
    logic       cpu_dc;
    logic       cpu_busy;
    logic       ready;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       oled_rst_n;
    logic       oled_cs_n;
    logic       oled_dc;

    logic [7:0] tbl [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
        8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
        8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_rise = -1;
    logic dc_prev = 1'b0;
    logic cs_prev = 1'b1;
    logic [2:0] sr;

    oled_boot_seq #(.SIMULATE("TRUE")) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_init  (soft_init),
        .cpu_wr     (cpu_wr),
        .cpu_data   (cpu_data),
        .cpu_dc     (cpu_dc),
        .cpu_busy   (cpu_busy),
        .ready      (ready),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_done   (spi_done),
        .oled_rst_n (oled_rst_n),
        .oled_cs_n  (oled_cs_n),
        .oled_dc    (oled_dc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model, reset by the same rst as the DUT
    always @(posedge clk or negedge rst) begin
        if (!rst) sr <= 3'b000;
        else      sr <= {sr[1:0], spi_start};
    end
    assign spi_done = sr[2];

    always @(negedge clk) begin
        dc_prev <= oled_dc;
        cs_prev <= oled_cs_n;
        if (spi_start === 1'b1)
            obs_q.push_back('{cyc, oled_cs_n, oled_dc, spi_data, dc_prev});
        if (oled_cs_n === 1'b1 && cs_prev === 1'b0)
            last_rise <= cyc;
    end

    task automatic wait_obs(input int n, input int lim, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < lim) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic drive_wr(input logic [7:0] d, input logic dv,
                            output int w);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_data = d; cpu_dc = dv; w = cyc;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic push_boot();
        for (int i = 0; i < 25; i++) exp_q.push_back('{1'b0, tbl[i]});
    endtask

    task automatic test_reset();
        rst = 1'b0; soft_init = 1'b0; cpu_wr = 1'b0;
        cpu_data = 8'h00; cpu_dc = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({oled_rst_n, oled_cs_n, oled_dc, spi_start, spi_data,
             ready, cpu_busy} !== 14'b0_1_0_0_00000000_0_1) begin
            n_fail++;
            $display("FAIL reset_vals: got rst_n=%b cs_n=%b dc=%b st=%b d=%h rdy=%b busy=%b",
                     oled_rst_n, oled_cs_n, oled_dc, spi_start, spi_data,
                     ready, cpu_busy);
        end
    endtask

    task automatic test_boot();
        int lows = 0, highs = 0, t = 0;
        bit ok;
        obs_t o;
        exp_t e;
        push_boot();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        while (oled_rst_n !== 1'b1 && lows < 50) begin
            lows++; @(negedge clk);
        end
        n_chk++;
        if (lows != 4) begin
            n_fail++;
            $display("FAIL rst_low_len: got %0d want 4", lows);
        end
        while (oled_cs_n !== 1'b0 && highs < 50) begin
            highs++; @(negedge clk);
        end
        n_chk++;
        if (highs != 4) begin
            n_fail++;
            $display("FAIL rst_wait_len: got %0d want 4", highs);
        end
        n_chk++;
        if (spi_start !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_setup: spi_start=%b with cs fall, want 0",
                     spi_start);
        end
        @(negedge clk);
        n_chk++;
        if (spi_start !== 1'b1 || spi_data !== 8'hAE || oled_dc !== 1'b0) begin
            n_fail++;
            $display("FAIL first_byte: st=%b d=%h dc=%b want 1 AE 0",
                     spi_start, spi_data, oled_dc);
        end
        wait_obs(25, 400, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL boot_count: got %0d starts want 25", obs_q.size());
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (o.data !== e.data || o.dc !== e.dc || o.cs_n !== 1'b0) begin
                n_fail++;
                $display("FAIL boot_byte%0d: got %h dc=%b cs_n=%b want %h dc=%b cs_n=0",
                         i, o.data, o.dc, o.cs_n, e.data, e.dc);
            end
        end
        do begin @(negedge clk); t++; end
        while (spi_done !== 1'b1 && t < 20);
        n_chk++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_early: got %b at last done want 0", ready);
        end
        @(negedge clk);
        n_chk++;
        if (ready !== 1'b1 || cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_set: got ready=%b busy=%b want 1 0",
                     ready, cpu_busy);
        end
    endtask

    task automatic test_write_cs_high();
        int t = 0, w = 0, idle = 0;
        bit ok;
        obs_t o;
        while (oled_cs_n !== 1'b1 && t < 30) begin
            @(negedge clk); t++;
        end
        n_chk++;
        if (oled_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_release_boot: cs_n=%b want 1", oled_cs_n);
        end
        exp_q.push_back('{1'b1, 8'h55});
        drive_wr(8'h55, 1'b1, w);
        @(negedge clk);
        n_chk++;
        if (oled_cs_n !== 1'b0 || cpu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_cs_on: cs_n=%b busy=%b want 0 1",
                     oled_cs_n, cpu_busy);
        end
        wait_obs(1, 20, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_start: got no spi_start want 1");
        end
        if (ok) begin
            o = obs_q.pop_front();
            void'(exp_q.pop_front());
            n_chk++;
            if (o.data !== 8'h55 || o.dc !== 1'b1 || o.cyc != w + 3) begin
                n_fail++;
                $display("FAIL wr_byte: got %h dc=%b lat=%0d want 55 dc=1 lat=3",
                         o.data, o.dc, o.cyc - w);
            end
        end
        t = 0;
        do begin @(negedge clk); t++; end
        while (spi_done !== 1'b1 && t < 20);
        @(negedge clk);
        n_chk++;
        if (cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_busy_clr: got %b want 0", cpu_busy);
        end
        while (oled_cs_n === 1'b0 && idle < 20) begin
            idle++; @(negedge clk);
        end
        n_chk++;
        if (idle != 4) begin
            n_fail++;
            $display("FAIL cs_idle: got %0d low cycles want 4", idle);
        end
    endtask

    task automatic test_back_to_back();
        int t = 0, w1 = 0, w2 = 0, w3 = 0;
        bit ok;
        obs_t o;
        drive_wr(8'h21, 1'b0, w1);
        do begin @(negedge clk); t++; end
        while (cpu_busy !== 1'b0 && t < 50);
        n_chk++;
        if (cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b want 0", cpu_busy);
        end
        drive_wr(8'hFF, 1'b1, w2);
        drive_wr(8'hC3, 1'b1, w3);
        n_chk++;
        if (cpu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_third_busy: got %b want 1", cpu_busy);
        end
        exp_q.push_back('{1'b0, 8'h21});
        exp_q.push_back('{1'b1, 8'hFF});
        wait_obs(2, 40, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", obs_q.size());
        end
        if (ok) begin
            o = obs_q.pop_front();
            void'(exp_q.pop_front());
            n_chk++;
            if (o.data !== 8'h21 || o.dc !== 1'b0 || o.cyc != w1 + 3) begin
                n_fail++;
                $display("FAIL b2b_first: got %h dc=%b lat=%0d want 21 0 3",
                         o.data, o.dc, o.cyc - w1);
            end
            o = obs_q.pop_front();
            void'(exp_q.pop_front());
            n_chk++;
            if (o.data !== 8'hFF || o.dc !== 1'b1 || o.prev_dc !== 1'b0
                || o.cyc != w2 + 2) begin
                n_fail++;
                $display("FAIL b2b_second: got %h dc=%b prev=%b lat=%0d want FF 1 0 2",
                         o.data, o.dc, o.prev_dc, o.cyc - w2);
            end
            n_chk++;
            if (last_rise >= w1) begin
                n_fail++;
                $display("FAIL b2b_cs_rise: cs rose at %0d, after wr at %0d",
                         last_rise, w1);
            end
        end
        repeat (30) @(negedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_drop: got %0d extra starts want 0",
                     obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_soft_init();
        int t = 0, w = 0;
        bit ok;
        obs_t o;
        exp_t e;
        exp_q.push_back('{1'b1, 8'h5A});
        push_boot();
        drive_wr(8'h5A, 1'b1, w);
        wait_obs(1, 20, ok);
        @(posedge clk); #1 soft_init = 1'b1;
        @(posedge clk); #1 soft_init = 1'b0;
        do begin @(negedge clk); t++; end
        while (spi_done !== 1'b1 && t < 20);
        @(negedge clk);
        n_chk++;
        if (oled_rst_n !== 1'b0 || ready !== 1'b0 || cpu_busy !== 1'b1
            || oled_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_restart: rst_n=%b rdy=%b busy=%b cs_n=%b want 0 0 1 1",
                     oled_rst_n, ready, cpu_busy, oled_cs_n);
        end
        wait_obs(26, 400, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL soft_count: got %0d want 26", obs_q.size());
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (o.data !== e.data || o.dc !== e.dc || o.cs_n !== 1'b0) begin
                n_fail++;
                $display("FAIL soft_byte%0d: got %h dc=%b cs_n=%b want %h dc=%b",
                         i, o.data, o.dc, o.cs_n, e.data, e.dc);
            end
        end
        t = 0;
        while (ready !== 1'b1 && t < 40) begin
            @(negedge clk); t++;
        end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        obs_t o;
        exp_t e;
        @(posedge clk); #1;
        soft_init = 1'b1; cpu_wr = 1'b1; cpu_data = 8'h77; cpu_dc = 1'b1;
        @(posedge clk); #1;
        soft_init = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        n_chk++;
        if (oled_rst_n !== 1'b0 || ready !== 1'b0 || cpu_busy !== 1'b1
            || oled_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_ready_st: rst_n=%b rdy=%b busy=%b cs_n=%b want 0 0 1 1",
                     oled_rst_n, ready, cpu_busy, oled_cs_n);
        end
        push_boot();
        wait_obs(11, 200, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL pre_rst_count: got %0d want 11", obs_q.size());
        end
        for (int i = 0; i < 11 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (o.data !== e.data || o.dc !== e.dc) begin
                n_fail++;
                $display("FAIL pre_rst_byte%0d: got %h dc=%b want %h dc=%b",
                         i, o.data, o.dc, e.data, e.dc);
            end
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({oled_rst_n, oled_cs_n, oled_dc, spi_start, spi_data,
             ready, cpu_busy} !== 14'b0_1_0_0_00000000_0_1) begin
            n_fail++;
            $display("FAIL async_rst: rst_n=%b cs_n=%b dc=%b st=%b d=%h rdy=%b busy=%b",
                     oled_rst_n, oled_cs_n, oled_dc, spi_start, spi_data,
                     ready, cpu_busy);
        end
        repeat (3) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        push_boot();
        @(posedge clk); #1 rst = 1'b1;
        wait_obs(25, 400, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rerun_count: got %0d want 25", obs_q.size());
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (o.data !== e.data || o.dc !== e.dc || o.cs_n !== 1'b0) begin
                n_fail++;
                $display("FAIL rerun_byte%0d: got %h dc=%b cs_n=%b want %h dc=%b",
                         i, o.data, o.dc, o.cs_n, e.data, e.dc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boot();
        test_write_cs_high();
        test_back_to_back();
        test_soft_init();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_boot_seq.md
Name: oled_boot_seq

Overview:
Sequences the Arduboy SSD1306 OLED: drives the power-up reset pulse, streams the fixed init command list through the shared SPI byte master, then hands the SPI/DC/CS path to the CPU. It sits between the core's OLED write port and the SPI master that drives ja[3] (CS), ja[5] (RST) and ja[7] (DC). It also owns CS framing, deasserting CS after an idle timeout.

Parameters:
SIMULATE, "FALSE", "TRUE" forces RST_CYCLES, WAIT_CYCLES and CS_IDLE to 4.
RST_CYCLES, 120, cycles oled_rst_n is held low (10 us at 12 MHz).
WAIT_CYCLES, 1200, cycles to wait after reset release before the first command.
CS_IDLE, 8, idle cycles in READY before oled_cs_n is deasserted.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
soft_init  in  1  one-cycle pulse; reruns the full boot sequence
cpu_wr  in  1  one-cycle write strobe from the core
cpu_data  in  8  byte to send
cpu_dc  in  1  0 = command, 1 = data
cpu_busy  out  1  high while a write cannot be accepted
ready  out  1  boot sequence complete
spi_start  out  1  one-cycle pulse to the SPI master
spi_data  out  8  byte for the SPI master, valid when spi_start is high
spi_done  in  1  one-cycle pulse from the SPI master at end of byte
oled_rst_n  out  1  OLED reset pin (ja[5])
oled_cs_n  out  1  OLED chip select (ja[3])
oled_dc  out  1  OLED D/C (ja[7])

Behaviour:
- All outputs are registered.
- Reset values: oled_rst_n=0, oled_cs_n=1, oled_dc=0, spi_start=0, spi_data=0, ready=0, cpu_busy=1. State=RST_LOW, counters=0, idx=0.
- RST_LOW: count RST_CYCLES cycles. On the last cycle set oled_rst_n=1 and go to RST_WAIT.
- RST_WAIT: count WAIT_CYCLES cycles, then go to CS_ON with idx=0.
- CS_ON: one cycle with oled_cs_n=0. Guarantees one cycle of CS setup before any spi_start. Next state is INIT_SEND during boot, XFER_SEND when a CPU write is pending.
- INIT_SEND: one cycle. Drives oled_dc=0, spi_data=rom[idx], spi_start=1, then goes to INIT_WAIT.
- INIT_WAIT: wait for spi_done.
  - If idx==INIT_LEN-1: go to READY, ready=1, cpu_busy=0, idle counter cleared.
  - Otherwise: idx+1, back to INIT_SEND.
  - CS stays low across the whole init burst.
- READY:
  - The idle counter increments while cs_n=0 and there is no cpu_wr. At CS_IDLE it sets oled_cs_n=1 and stops.
  - On cpu_wr: latch cpu_data/cpu_dc, set cpu_busy=1 the next cycle. Go to CS_ON if cs_n=1, else XFER_SEND.
- XFER_SEND: one cycle. oled_dc=latched dc and spi_data=latched byte, both updated in the same cycle that spi_start=1. Then go to XFER_WAIT.
- XFER_WAIT: on spi_done, return to READY, cpu_busy=0 the next cycle, idle counter cleared.
- Minimum CPU write latency from cpu_wr to spi_start:
  - 2 cycles with CS already low.
  - 3 cycles with CS high.
- cpu_wr while cpu_busy=1, including during boot: ignored, no state change.
- spi_done outside INIT_WAIT/XFER_WAIT: ignored.
- soft_init:
  - In READY: ready=0, cpu_busy=1, oled_cs_n=1, oled_rst_n=0, state RST_LOW, counters cleared.
  - In a WAIT state: latched, acted on after spi_done.
  - In RST_LOW/RST_WAIT/CS_ON/SEND states: ignored.
- cpu_wr and soft_init in the same READY cycle: soft_init wins, the write is dropped.
- Async reset mid-transfer: all state returns to reset values immediately. The SPI master is reset by the same rst.
- Counters are sized by $clog2 of the largest of RST_CYCLES, WAIT_CYCLES and CS_IDLE, and saturate (no wrap).
- idx is 5 bits, and INIT_LEN must be 32 or less.

Decomposition:
- Package oled_seq_pkg holds:
  - the state encoding: RST_LOW, RST_WAIT, CS_ON, INIT_SEND, INIT_WAIT, READY, XFER_SEND, XFER_WAIT;
  - INIT_LEN=25;
  - the SSD1306 init bytes, in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- One sub-module, oled_init_rom: combinational idx to byte lookup from the package constants.

Test Plan:
- SIMULATE="TRUE", release rst. Required: oled_rst_n low for exactly 4 cycles, high 4 cycles, then cs_n falls one cycle before the first spi_start with spi_data=8'hAE, dc=0.
- Model the SPI master to return spi_done 3 cycles after each spi_start. Required: 25 spi_start pulses, bytes match the table, last is 8'hAF, ready=1 and cpu_busy=0 one cycle after the 25th spi_done.
- In READY with cs_n=1, cpu_wr with data=8'h55, dc=1. Required: cs_n=0 next cycle, spi_start with spi_data=8'h55 and dc=1 3 cycles after cpu_wr; cs_n returns high 4 idle cycles after spi_done.
- Two back-to-back writes, 8'h21 (dc=0) then 8'hFF (dc=1), with the second issued 1 cycle after cpu_busy falls. Required: cs_n never rises between them, dc switches 0 to 1 only on the second spi_start. A third cpu_wr asserted while busy produces no spi_start.
- soft_init pulse during XFER_WAIT. Required: the transfer completes on spi_done, then oled_rst_n=0, ready=0, and the full 25-byte sequence repeats.
- rst low mid INIT_WAIT at idx=10. Required: outputs return to reset values asynchronously, and after release the sequence restarts from byte 8'hAE.
